// File: rtl/wallace_mac.sv
// Multiply-accumulate block: a 4x4 Wallace-tree multiplier feeds a frame accumulator.
// Frames end on a 'last' pair or after N_MAX pairs. The result is held until the consumer takes it.

module wallace_ha (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

module wallace_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic c
);
    assign s = a ^ b ^ ci;
    assign c = (a & b) | (a & ci) | (b & ci);
endmodule

module wallace (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] prod
);
    // pp[i][j] = B[i] & A[j], weight i+j
    logic [3:0] pp [4];
    logic s1_1, c1_1, s1_2, c1_2, s1_3, c1_3, s1_4, c1_4, s1_5, c1_5;
    logic s2_3, c2_3, s2_4, c2_4, s2_5, c2_5, s2_6, c2_6;
    logic [7:0] row_x, row_y;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            pp[i] = A & {4{B[i]}};
        end
    end

    // First reduction layer: columns 1..5 compressed in parallel
    wallace_ha u_h1_1 (.a(pp[0][1]), .b(pp[1][0]), .s(s1_1), .c(c1_1));
    wallace_fa u_f1_2 (.a(pp[0][2]), .b(pp[1][1]), .ci(pp[2][0]), .s(s1_2), .c(c1_2));
    wallace_fa u_f1_3 (.a(pp[0][3]), .b(pp[1][2]), .ci(pp[2][1]), .s(s1_3), .c(c1_3));
    wallace_fa u_f1_4 (.a(pp[1][3]), .b(pp[2][2]), .ci(pp[3][1]), .s(s1_4), .c(c1_4));
    wallace_ha u_h1_5 (.a(pp[2][3]), .b(pp[3][2]), .s(s1_5), .c(c1_5));

    // Second layer leaves at most two bits per column
    wallace_fa u_f2_3 (.a(s1_3), .b(pp[3][0]), .ci(c1_2), .s(s2_3), .c(c2_3));
    wallace_ha u_h2_4 (.a(s1_4), .b(c1_3), .s(s2_4), .c(c2_4));
    wallace_ha u_h2_5 (.a(s1_5), .b(c1_4), .s(s2_5), .c(c2_5));
    wallace_ha u_h2_6 (.a(pp[3][3]), .b(c1_5), .s(s2_6), .c(c2_6));

    assign row_x = {1'b0, s2_6, s2_5, s2_4, s2_3, s1_2, s1_1, pp[0][0]};
    assign row_y = {c2_6, c2_5, c2_4, c2_3, 1'b0, c1_1, 2'b00};

    // Final carry-propagate add; the true product never exceeds 8 bits
    assign prod = row_x + row_y;
endmodule

module wallace_mac #(
    parameter int ACC_W = 12,
    parameter int N_MAX = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       A,
    input  logic [3:0]       B,
    input  logic             last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc,
    output logic [4:0]       count,
    output logic             ovf,
    output logic [1:0]       state_dbg
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid may not depend on ready, and the sender holds its data until the transfer.
    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic             accept, take, final_pair;
    logic [3:0]       op_a, op_b;
    logic             stg_v;
    logic [7:0]       prod;
    logic [ACC_W:0]   sum_ext;
    logic [5:0]       accepted_total;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == DONE);
    assign state_dbg = state;

    // clr discards any pair offered in the same cycle
    assign accept = in_valid && in_ready && !clr;
    assign take   = out_valid && out_ready;

    // Pairs accepted so far include the one still in the operand stage
    assign accepted_total = {1'b0, count} + {5'd0, stg_v} + 6'd1;
    assign final_pair     = last || (accepted_total == 6'(N_MAX));

    wallace u_mul (
        .A   (op_a),
        .B   (op_b),
        .prod(prod)
    );

    assign sum_ext = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, prod};

    always_comb begin
        state_nx = state;
        if (clr) begin
            state_nx = ACCUM;
        end else begin
            case (state)
                ACCUM:   if (accept && final_pair) state_nx = DRAIN;
                DRAIN:   state_nx = DONE;
                DONE:    if (take) state_nx = ACCUM;
                default: state_nx = ACCUM;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ACCUM;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= 4'd0;
            op_b  <= 4'd0;
            stg_v <= 1'b0;
        end else if (clr) begin
            stg_v <= 1'b0;
        end else begin
            stg_v <= accept;
            if (accept) begin
                op_a <= A;
                op_b <= B;
            end
        end
    end

    // The operand stage is always empty in DONE, so take and stg_v never collide
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            count <= 5'd0;
            ovf   <= 1'b0;
        end else if (clr || take) begin
            acc   <= '0;
            count <= 5'd0;
            ovf   <= 1'b0;
        end else if (stg_v) begin
            acc   <= sum_ext[ACC_W-1:0];
            count <= count + 5'd1;
            ovf   <= ovf | sum_ext[ACC_W];
        end
    end
endmodule

// File: tb/tb_wallace_mac.sv
// Bench for wallace_mac: a 12-bit and an 8-bit accumulator instance share one stimulus
// stream and are checked against a plain-arithmetic frame-sum model.

module tb_wallace_mac;
    logic clk, rst, clr, in_valid, last, out_ready;
    logic [3:0] A, B;

    logic in_ready, out_valid, ovf;
    logic [11:0] acc;
    logic [4:0] count;
    logic [1:0] state_dbg;

    logic in_ready8, out_valid8, ovf8;
    logic [7:0] acc8;
    logic [4:0] count8;
    logic [1:0] state_dbg8;

    int n_cmp = 0;
    int n_err = 0;

    wallace_mac #(.ACC_W(12), .N_MAX(16)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .last(last), .out_valid(out_valid), .out_ready(out_ready),
        .acc(acc), .count(count), .ovf(ovf), .state_dbg(state_dbg)
    );

    wallace_mac #(.ACC_W(8), .N_MAX(16)) u_dut8 (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready8),
        .A(A), .B(B), .last(last), .out_valid(out_valid8), .out_ready(out_ready),
        .acc(acc8), .count(count8), .ovf(ovf8), .state_dbg(state_dbg8)
    );

    // Observed bundle from both instances, compared as one value
    logic [35:0] obs;
    assign obs = {in_ready, out_valid, count, ovf, acc, ovf8, acc8, in_ready8, out_valid8, count8};

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: s is the plain integer sum of accepted products in the frame
    function automatic logic [35:0] expv(input logic ir, input logic ov, input int cnt, input int s);
        logic [35:0] r;
        r[35]    = ir;
        r[34]    = ov;
        r[33:29] = cnt[4:0];
        r[28]    = (s >= 4096);
        r[27:16] = s[11:0];
        r[15]    = (s >= 256);
        r[14:7]  = s[7:0];
        r[6]     = ir;
        r[5]     = ov;
        r[4:0]   = cnt[4:0];
        return r;
    endfunction

    // driver tasks
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic drive(input logic v, input logic [3:0] a, input logic [3:0] b, input logic l);
        in_valid = v;
        A        = a;
        B        = b;
        last     = l;
    endtask

    task automatic idle();
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        clr       = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #3;
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_state: got %h want %h", obs, expv(1, 0, 0, 0));
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_basic();
        drive(1, 3, 5, 0);
        tick();
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++; $display("FAIL basic_lat1: got %h want %h", obs, expv(1, 0, 0, 0));
        end
        drive(1, 15, 15, 0);
        tick();
        n_cmp++;
        if (obs !== expv(1, 0, 1, 15)) begin
            n_err++; $display("FAIL basic_lat2: got %h want %h", obs, expv(1, 0, 1, 15));
        end
        drive(1, 7, 2, 1);
        tick();
        n_cmp++;
        if (obs !== expv(0, 0, 2, 240)) begin
            n_err++; $display("FAIL basic_drain: got %h want %h", obs, expv(0, 0, 2, 240));
        end
        idle();
        tick();
        n_cmp++;
        if (obs !== expv(0, 1, 3, 254)) begin
            n_err++; $display("FAIL basic_done: got %h want %h", obs, expv(0, 1, 3, 254));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++; $display("FAIL basic_take: got %h want %h", obs, expv(1, 0, 0, 0));
        end
    endtask

    task automatic test_nmax();
        for (int i = 1; i <= 16; i++) begin
            drive(1, 15, 15, 0);
            tick();
            n_cmp++;
            if (obs !== expv(i < 16, 0, i - 1, (i - 1) * 225)) begin
                n_err++;
                $display("FAIL nmax_step%0d: got %h want %h", i, obs, expv(i < 16, 0, i - 1, (i - 1) * 225));
            end
        end
        for (int i = 0; i < 3; i++) begin
            drive(1, 15, 15, 0);
            tick();
            n_cmp++;
            if (obs !== expv(0, 1, 16, 3600)) begin
                n_err++; $display("FAIL nmax_done%0d: got %h want %h", i, obs, expv(0, 1, 16, 3600));
            end
        end
        idle();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++; $display("FAIL nmax_take: got %h want %h", obs, expv(1, 0, 0, 0));
        end
    endtask

    task automatic test_ovf();
        drive(1, 15, 15, 0);
        tick();
        drive(1, 15, 15, 1);
        tick();
        idle();
        tick();
        n_cmp++;
        if (obs !== expv(0, 1, 2, 450)) begin
            n_err++; $display("FAIL ovf_done: got %h want %h", obs, expv(0, 1, 2, 450));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++; $display("FAIL ovf_take: got %h want %h", obs, expv(1, 0, 0, 0));
        end
    endtask

    task automatic test_done_hold();
        int s = 0;
        int n = $urandom_range(1, 5);
        for (int i = 0; i < n; i++) begin
            logic [3:0] a = 4'($urandom_range(0, 15));
            logic [3:0] b = 4'($urandom_range(0, 15));
            drive(1, a, b, i == n - 1);
            s += int'(a) * int'(b);
            tick();
        end
        idle();
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
            tick();
            n_cmp++;
            if (obs !== expv(0, 1, n, s)) begin
                n_err++; $display("FAIL done_hold%0d: got %h want %h", i, obs, expv(0, 1, n, s));
            end
        end
        idle();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++; $display("FAIL done_hold_take: got %h want %h", obs, expv(1, 0, 0, 0));
        end
    endtask

    task automatic test_clr();
        drive(1, 4, 4, 0);
        tick();
        drive(1, 2, 2, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++; $display("FAIL clr_mid: got %h want %h", obs, expv(1, 0, 0, 0));
        end
        drive(1, 1, 1, 1);
        tick();
        idle();
        tick();
        n_cmp++;
        if (obs !== expv(0, 1, 1, 1)) begin
            n_err++; $display("FAIL clr_after: got %h want %h", obs, expv(0, 1, 1, 1));
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++; $display("FAIL clr_done: got %h want %h", obs, expv(1, 0, 0, 0));
        end
    endtask

    task automatic test_async_rst();
        drive(1, 5, 8, 0);
        tick();
        idle();
        tick();
        n_cmp++;
        if (obs !== expv(1, 0, 1, 40)) begin
            n_err++; $display("FAIL arst_pre: got %h want %h", obs, expv(1, 0, 1, 40));
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++; $display("FAIL arst_mid: got %h want %h", obs, expv(1, 0, 0, 0));
        end
        tick();
        rst = 1'b0;
        drive(1, 6, 7, 1);
        tick();
        idle();
        tick();
        n_cmp++;
        if (obs !== expv(0, 1, 1, 42)) begin
            n_err++; $display("FAIL arst_first: got %h want %h", obs, expv(0, 1, 1, 42));
        end
        #2 rst = 1'b1;
        #1;
        n_cmp++;
        if (obs !== expv(1, 0, 0, 0)) begin
            n_err++; $display("FAIL arst_done: got %h want %h", obs, expv(1, 0, 0, 0));
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_sweep();
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                drive(1, 4'(a), 4'(b), 1);
                tick();
                idle();
                tick();
                n_cmp++;
                if (obs !== expv(0, 1, 1, a * b)) begin
                    n_err++;
                    $display("FAIL sweep_%0dx%0d: got %h want %h", a, b, obs, expv(0, 1, 1, a * b));
                end
                out_ready = 1'b1;
                tick();
                out_ready = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        for (int f = 0; f < 40; f++) begin
            int s = 0;
            int n = 0;
            bit done = 0;
            exp_q.delete();
            while (!done) begin
                logic v = ($urandom_range(0, 3) != 0);
                logic [3:0] a = 4'($urandom_range(0, 15));
                logic [3:0] b = 4'($urandom_range(0, 15));
                logic l = ($urandom_range(0, 9) == 0);
                int prev_s = s;
                int prev_n = n;
                drive(v, a, b, l);
                tick();
                if (v) begin
                    exp_q.push_back(8'(int'(a) * int'(b)));
                    s += int'(a) * int'(b);
                    n++;
                    if (l || n == 16) done = 1;
                end
                n_cmp++;
                if (obs !== expv(!done, 0, prev_n, prev_s)) begin
                    n_err++;
                    $display("FAIL b2b_f%0d_run: got %h want %h", f, obs, expv(!done, 0, prev_n, prev_s));
                end
            end
            drive(1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
            tick();
            s = 0;
            foreach (exp_q[i]) s += int'(exp_q[i]);
            for (int w = $urandom_range(0, 3); w >= 0; w--) begin
                n_cmp++;
                if (obs !== expv(0, 1, exp_q.size(), s)) begin
                    n_err++;
                    $display("FAIL b2b_f%0d_done: got %h want %h", f, obs, expv(0, 1, exp_q.size(), s));
                end
                if (w > 0) tick();
            end
            idle();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            n_cmp++;
            if (obs !== expv(1, 0, 0, 0)) begin
                n_err++; $display("FAIL b2b_f%0d_take: got %h want %h", f, obs, expv(1, 0, 0, 0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_nmax();
        test_ovf();
        test_done_hold();
        test_clr();
        test_async_rst();
        test_sweep();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/wallace_mac.md
WALLACE_MAC -- requirements
Module: wallace_mac

Interface
REQ-001 Parameter ACC_W, default 12: accumulator width in bits, SHALL be at least 8.
REQ-002 Parameter N_MAX, default 16: maximum samples per accumulation frame, SHALL be between 1 and 31.
REQ-003 clk  input  1  sole clock; all state SHALL update on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 clr  input  1  synchronous frame abort and clear.
REQ-006 in_valid  input  1  operand pair present.
REQ-007 in_ready  output  1  block accepts an operand pair this cycle.
REQ-008 A  input  4  unsigned multiplicand.
REQ-009 B  input  4  unsigned multiplier.
REQ-010 last  input  1  qualifies the accepted pair as the final pair of the frame.
REQ-011 out_valid  output  1  frame result available.
REQ-012 out_ready  input  1  consumer takes the result.
REQ-013 acc  output  ACC_W  running or final sum of products.
REQ-014 count  output  5  number of pairs accumulated in the current frame.
REQ-015 ovf  output  1  sticky flag: the accumulator wrapped during this frame.

Function
REQ-016 The product SHALL come from an instantiated wallace (ports A, B, prod[7:0]) driven by the registered operands; no behavioural multiply SHALL be used.
REQ-017 The FSM SHALL have exactly three states: ACCUM, DRAIN and DONE; the reset state SHALL be ACCUM.
REQ-018 in_ready SHALL be 1 only in ACCUM; otherwise 0; it SHALL be purely a function of state.
REQ-019 Accept is in_valid && in_ready; on accept, edge k SHALL capture A and B into operand registers and set a stage valid bit.
REQ-020 At edge k+1, acc SHALL become acc + zero-extended prod, modulo 2^ACC_W, and count SHALL increment; the latency from accept to acc update is therefore two edges.
REQ-021 Back-to-back accepts SHALL be supported at one pair per cycle with no bubbles.
REQ-022 ovf SHALL set on any carry out of bit ACC_W-1 and SHALL stay set until cleared.
REQ-023 Accepting a pair with last=1, or a pair that brings the accepted total to N_MAX, SHALL move the FSM from ACCUM to DRAIN.
REQ-024 DRAIN SHALL last exactly one cycle (the final addition) and then move to DONE.
REQ-025 In DONE, out_valid SHALL be 1, and acc, count and ovf SHALL be held stable.
REQ-026 When out_valid && out_ready, the next edge SHALL zero acc, count and ovf and return to ACCUM.
REQ-027 Pairs presented while in_ready=0 SHALL be ignored and SHALL not be lost silently; the upstream holds them per the handshake.
REQ-028 in_valid=1 with in_ready=0 SHALL have no effect.
REQ-029 clr=1 in any state SHALL, at the next edge, zero acc, count, ovf and the stage valid bit and enter ACCUM; clr SHALL take priority over accept, drain and out_ready.
REQ-030 A pair accepted in the same cycle as clr SHALL be discarded.
REQ-031 out_valid SHALL be 0 in ACCUM and DRAIN.
REQ-032 A frame with zero pairs is not possible; DONE is reached only via an accepted pair.

Reset
REQ-033 On rst=1, immediately and independently of clk: state=ACCUM, acc=0, count=0, ovf=0, out_valid=0, operand registers=0, stage valid=0.
REQ-034 During rst=1, in_ready=1.
REQ-035 rst asserted mid-frame or in DONE SHALL discard all partial results.
REQ-036 After rst deasserts, the first rising edge SHALL be able to accept a pair.

Verification
REQ-037 Reset, then pairs (3,5),(15,15),(7,2 last) on consecutive cycles -> out_valid=1 two edges after the last accept; acc=254, count=3, ovf=0.
REQ-038 16 pairs of (15,15) without last -> DRAIN entered automatically; acc=3600, count=16, ovf=0; in_ready=0 from the 16th accept until the result is taken.
REQ-039 With ACC_W=8: pairs (15,15),(15,15 last) -> acc=194, ovf=1; after the out_ready handshake, acc=0 and ovf=0.
REQ-040 In DONE, hold out_ready=0 for 5 cycles while toggling in_valid and A/B -> acc, count and out_valid stay stable and no pair is accepted.
REQ-041 Accept (4,4), assert clr together with the next accept of (2,2) -> acc=0, count=0, state ACCUM; a following (1,1 last) gives acc=1, count=1.
REQ-042 Assert rst asynchronously between edges mid-frame with acc=40 -> acc=0 and out_valid=0 before the next edge; the sweep of all 256 (A,B) pairs as single-pair frames gives acc=A*B for each.
